// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared rounding-mode encodings and fp32 constants
package fp_pkg;

    typedef enum logic [1:0] {
        RM_RNE   = 2'b00,
        RM_TRUNC = 2'b01,
        RM_FLOOR = 2'b10,
        RM_CEIL  = 2'b11
    } rmode_e;

    localparam logic [31:0] FP32_ONE      = 32'h3F80_0000;
    localparam logic [31:0] FP32_QNAN_BIT = 32'h0040_0000;

endpackage

// File: rtl/fp_round_pipe_if.sv
// rtl/fp_round_pipe_if.sv - operand/result streaming bundle of the rounding pipe
interface fp_round_pipe_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 16
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             out_inexact;

    // Producer of operands and consumer of results.
    modport master (
        output in_valid, in_data, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_inexact
    );

    // The rounding unit itself.
    modport slave (
        input  in_valid, in_data, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_inexact
    );

endinterface

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - classify an operand and decide how it rounds to an integral value
module fp_round_decide
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W+MAN_W:0]   data,
    input  rmode_e                 mode,
    output logic                   sign,
    output logic [EXP_W+MAN_W-1:0] base,
    output logic [EXP_W+MAN_W-1:0] add,
    output logic                   up,
    output logic                   inexact
);
    localparam int MW   = EXP_W + MAN_W;
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [MW-1:0]    ONE_MAG  = MW'(BIAS) << MAN_W;
    localparam logic [MW-1:0]    QBIT     = MW'(1) << (MAN_W - 1);

    logic [MW-1:0]    mag;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] man;
    logic [31:0]      e32;
    logic [31:0]      f32;
    logic [MW-1:0]    unit;
    logic [MW-1:0]    half;
    logic             rbit;
    logic             sbit;
    logic             lbit;
    logic             away;

    assign sign = data[MW];
    assign mag  = data[MW-1:0];
    assign e    = data[MW-1:MAN_W];
    assign man  = data[MAN_W-1:0];
    assign e32  = 32'(e);

    // Directed modes move the magnitude up only when they point away from zero.
    assign away = (mode == RM_CEIL && !sign) || (mode == RM_FLOOR && sign);

    // The magnitude is split into a truncated base and the 2^f step added when rounding up.
    always_comb begin
        base    = mag;
        add     = '0;
        up      = 1'b0;
        inexact = 1'b0;
        f32     = '0;
        unit    = '0;
        half    = '0;
        rbit    = 1'b0;
        sbit    = 1'b0;
        lbit    = 1'b0;
        if (e == EXP_ONES) begin
            if (man != '0) begin
                base = mag | QBIT;
            end
        end else if (e32 >= 32'(BIAS + MAN_W) || mag == '0) begin
            base = mag;
        end else if (e32 < 32'(BIAS)) begin
            base    = '0;
            add     = ONE_MAG;
            inexact = 1'b1;
            up      = away || (mode == RM_RNE && e32 == 32'(BIAS - 1) && man != '0);
        end else begin
            f32     = 32'(BIAS + MAN_W) - e32;
            unit    = MW'(1) << f32;
            half    = unit >> 1;
            rbit    = |(mag & half);
            sbit    = |(mag & (half - MW'(1)));
            lbit    = |(mag & unit);
            base    = mag & ~(unit - MW'(1));
            add     = unit;
            inexact = rbit | sbit;
            up      = (away && (rbit || sbit)) || (mode == RM_RNE && rbit && (sbit || lbit));
        end
    end

endmodule

// File: rtl/fp_round_pipe.sv
// rtl/fp_round_pipe.sv - two-stage streaming round-to-integral unit with per-sample mode
module fp_round_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    fp_round_pipe_if.slave  bus
);
    localparam int MW = EXP_W + MAN_W;

    logic             s1_valid;
    logic             s1_sign;
    logic [MW-1:0]    s1_base;
    logic [MW-1:0]    s1_add;
    logic             s1_up;
    logic             s1_inexact;
    logic [TAG_W-1:0] s1_tag;

    logic             d_sign;
    logic [MW-1:0]    d_base;
    logic [MW-1:0]    d_add;
    logic             d_up;
    logic             d_inexact;

    logic             s2_load;
    logic             in_ready;
    logic             accept;
    logic             move;

    fp_round_decide #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_decide (
        .data    (bus.in_data),
        .mode    (rmode_e'(bus.in_mode)),
        .sign    (d_sign),
        .base    (d_base),
        .add     (d_add),
        .up      (d_up),
        .inexact (d_inexact)
    );

    // Output stage frees up when empty or when the consumer takes its result.
    assign s2_load      = !bus.out_valid || bus.out_ready;
    assign in_ready     = !s1_valid || s2_load;
    assign bus.in_ready = in_ready;
    assign accept       = bus.in_valid && in_ready;
    assign move         = s1_valid && s2_load;

    // Valid chain: each stage loads whenever it may advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid <= bus.in_valid;
            end
            if (s2_load) begin
                bus.out_valid <= s1_valid;
            end
        end
    end

    // Stage 1 captures the rounding decision for an accepted sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign    <= 1'b0;
            s1_base    <= '0;
            s1_add     <= '0;
            s1_up      <= 1'b0;
            s1_inexact <= 1'b0;
            s1_tag     <= '0;
        end else if (accept) begin
            s1_sign    <= d_sign;
            s1_base    <= d_base;
            s1_add     <= d_add;
            s1_up      <= d_up;
            s1_inexact <= d_inexact;
            s1_tag     <= bus.in_tag;
        end
    end

    // Stage 2 applies the increment; a mantissa carry ripples into the exponent.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_data    <= '0;
            bus.out_tag     <= '0;
            bus.out_inexact <= 1'b0;
        end else if (move) begin
            bus.out_data    <= {s1_sign, s1_up ? s1_base + s1_add : s1_base};
            bus.out_tag     <= s1_tag;
            bus.out_inexact <= s1_inexact;
        end
    end

endmodule

// File: tb/tb_fp_round_pipe.sv
// tb/tb_fp_round_pipe.sv - self-checking bench for fp_round_pipe
module tb_fp_round_pipe;
    import fp_pkg::*;

    typedef struct {
        logic [31:0] data;
        rmode_e      mode;
        logic [31:0] exp_data;
        logic        exp_inx;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    fp_round_pipe_if #(.EXP_W(8), .MAN_W(23), .TAG_W(16)) bus ();

    fp_round_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: real-valued floor/ceil/trunc/rint, result re-encoded from the integer.
    function automatic void ref_round(input logic [31:0] x, input rmode_e m,
                                      output logic [31:0] y, output logic inx);
        int     e;
        int     p;
        longint mf;
        longint mi;
        real    a;
        real    xr;
        real    r;
        real    fl;
        real    d;
        logic [63:0] t;
        e   = int'(x[30:23]);
        y   = x;
        inx = 1'b0;
        if (e == 255) begin
            if (x[22:0] != 23'd0) y = x | FP32_QNAN_BIT;
            return;
        end
        if (e >= 150) return;
        mf = (e == 0) ? longint'(x[22:0]) : longint'(x[22:0]) + 64'd8388608;
        a  = real'(mf) * (2.0 ** (((e == 0) ? 1 : e) - 150));
        xr = x[31] ? -a : a;
        case (m)
            RM_TRUNC: r = (xr >= 0.0) ? $floor(xr) : $ceil(xr);
            RM_FLOOR: r = $floor(xr);
            RM_CEIL:  r = $ceil(xr);
            default: begin
                fl = $floor(xr);
                d  = xr - fl;
                if (d > 0.5)      r = fl + 1.0;
                else if (d < 0.5) r = fl;
                else              r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
            end
        endcase
        inx = (r != xr);
        a   = (r < 0.0) ? -r : r;
        mi  = longint'(a);
        if (mi == 0) begin
            y = {x[31], 31'd0};
        end else begin
            p = 0;
            while ((mi >> (p + 1)) != 0) p++;
            t = 64'(mi) << (23 - p);
            y = {x[31], 8'(127 + p), t[22:0]};
        end
    endfunction

    function automatic logic [31:0] rand_word();
        logic [7:0]  e;
        logic [22:0] man;
        int          sel;
        sel = $urandom_range(0, 9);
        if (sel == 0)      e = 8'd0;
        else if (sel == 1) e = 8'd255;
        else               e = 8'($urandom_range(100, 160));
        man = 23'($urandom);
        if ($urandom_range(0, 3) == 0) man = man & 23'h7F0000;
        return {1'($urandom), e, man};
    endfunction

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    logic [15:0] tag_q[$];
    logic        inx_q[$];

    initial begin
        logic [31:0] ey;
        logic        ei;
        logic        hold_valid;
        logic [31:0] hold_data;
        logic [15:0] hold_tag;
        int          n;
        int          sent;
        int          recv;
        int          cyc;

        vecs.push_back('{32'hC0200000, RM_FLOOR, 32'hC0400000, 1'b1});
        vecs.push_back('{32'h40200000, RM_FLOOR, 32'h40000000, 1'b1});
        vecs.push_back('{32'h40200000, RM_RNE,   32'h40000000, 1'b1});
        vecs.push_back('{32'h40600000, RM_RNE,   32'h40800000, 1'b1});
        vecs.push_back('{32'h3F000000, RM_RNE,   32'h00000000, 1'b1});
        vecs.push_back('{32'h3F400000, RM_RNE,   FP32_ONE,     1'b1});
        vecs.push_back('{32'hBE99999A, RM_FLOOR, 32'hBF800000, 1'b1});
        vecs.push_back('{32'hBE99999A, RM_CEIL,  32'h80000000, 1'b1});
        vecs.push_back('{32'hBE99999A, RM_TRUNC, 32'h80000000, 1'b1});
        vecs.push_back('{32'h3FC00000, RM_CEIL,  32'h40000000, 1'b1});
        vecs.push_back('{32'h7F800001, RM_RNE,   32'h7FC00001, 1'b0});
        vecs.push_back('{32'hFF800000, RM_FLOOR, 32'hFF800000, 1'b0});
        vecs.push_back('{32'h4B000001, RM_CEIL,  32'h4B000001, 1'b0});
        vecs.push_back('{32'h80000000, RM_CEIL,  32'h80000000, 1'b0});
        vecs.push_back('{32'h40400000, RM_FLOOR, 32'h40400000, 1'b0});
        vecs.push_back('{32'hBFC00000, RM_TRUNC, 32'hBF800000, 1'b1});
        vecs.push_back('{32'h00000001, RM_CEIL,  FP32_ONE,     1'b1});
        vecs.push_back('{32'h00000001, RM_FLOOR, 32'h00000000, 1'b1});
        vecs.push_back('{32'hBF400000, RM_RNE,   32'hBF800000, 1'b1});

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_data", bus.out_data, 32'd0);
        check("rst_out_tag", bus.out_tag, 16'd0);
        check("rst_out_inexact", bus.out_inexact, 1'b0);

        // Directed vectors, one at a time through an empty pipe.
        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_data  = vecs[i].data;
            bus.in_mode  = vecs[i].mode;
            bus.in_tag   = 16'(16'h0100 + i);
            bus.in_valid = 1'b1;
            tick();
            bus.in_valid = 1'b0;
            n = 0;
            while (!bus.out_valid && n < 8) begin
                tick();
                n++;
            end
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
            check($sformatf("vec%0d_data", i), bus.out_data, vecs[i].exp_data);
            check($sformatf("vec%0d_inexact", i), bus.out_inexact, vecs[i].exp_inx);
            check($sformatf("vec%0d_tag", i), bus.out_tag, 16'(16'h0100 + i));
            tick();
        end

        // Random stream with random backpressure, checked in order against the model.
        sent = 0;
        recv = 0;
        cyc = 0;
        hold_valid = 1'b0;
        hold_data = '0;
        hold_tag = '0;
        while ((sent < 64 || recv < 64) && cyc < 3000) begin
            if (hold_valid) begin
                check("stall_valid", bus.out_valid, 1'b1);
                check("stall_data", bus.out_data, hold_data);
                check("stall_tag", bus.out_tag, hold_tag);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            if (sent < 64 && $urandom_range(0, 2) != 0) begin
                bus.in_valid = 1'b1;
                bus.in_data  = rand_word();
                bus.in_mode  = 2'($urandom_range(0, 3));
                bus.in_tag   = 16'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (bus.in_valid && bus.in_ready) begin
                ref_round(bus.in_data, rmode_e'(bus.in_mode), ey, ei);
                exp_q.push_back(ey);
                inx_q.push_back(ei);
                tag_q.push_back(bus.in_tag);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 1'b1, 1'b0);
                end else begin
                    check($sformatf("stream%0d_data", recv), bus.out_data, exp_q.pop_front());
                    check($sformatf("stream%0d_inexact", recv), bus.out_inexact, inx_q.pop_front());
                    check($sformatf("stream%0d_tag", recv), bus.out_tag, tag_q.pop_front());
                end
                recv++;
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            hold_tag   = bus.out_tag;
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        check("stream_recv_count", 64'(recv), 64'd64);

        // Fill both stages, then reset with everything in flight.
        bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        bus.in_data   = 32'h40200000;
        bus.in_mode   = RM_CEIL;
        bus.in_tag    = 16'hAAAA;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_data   = 32'h40600000;
        bus.in_tag    = 16'hBBBB;
        check("fill_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        check("full_out_valid", bus.out_valid, 1'b1);
        check("full_in_ready", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_out_data", bus.out_data, 32'd0);
        tick();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        tick();
        check("post_rst_no_stale", bus.out_valid, 1'b0);
        tick();
        check("post_rst_no_stale2", bus.out_valid, 1'b0);

        bus.in_data  = 32'hC0200000;
        bus.in_mode  = RM_FLOOR;
        bus.in_tag   = 16'h1234;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            tick();
            bus.in_valid = 1'b0;
            n++;
        end while (!bus.out_valid && n < 8);
        check("post_rst_latency", 64'(n), 64'd2);
        check("post_rst_data", bus.out_data, 32'hC0400000);
        check("post_rst_tag", bus.out_tag, 16'h1234);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
